// File: rtl/glitch_free_multi_pkg.sv
// glitch_free_multi_pkg: shared mode encodings and synchroniser depth for the debouncer
package glitch_free_multi_pkg;
  localparam int MODE_SYM    = 0;
  localparam int MODE_LEGACY = 1;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/glitch_free_chan.sv
// glitch_free_chan: one debounce channel with stability counter, accepted level and edge pulses
module glitch_free_chan
  import glitch_free_multi_pkg::*;
#(
  parameter int   CNT_W   = 22,
  parameter int   MODE    = MODE_SYM,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic out,
  output logic rise,
  output logic fall
);
  logic [CNT_W-1:0] cnt;
  logic match, flip;
  always_comb begin
    match = s == out;
    // legacy mode lets a falling sample through on its first edge
    flip  = !match && ((MODE == MODE_LEGACY && !s) || &cnt);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= RST_VAL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      out  <= flip ? s : out;
      cnt  <= (match || flip) ? '0 : cnt + 1'b1;
      rise <= flip && s;
      fall <= flip && !s;
    end
  end
endmodule

// File: rtl/glitch_free_multi.sv
// glitch_free_multi: N-channel both-edge debouncer with rise/fall pulses.
// Define GLITCH_FREE_MULTI_SYNC_EN to put a 2-flop synchroniser in front of every channel.
module glitch_free_multi
  import glitch_free_multi_pkg::*;
#(
  parameter int   N       = 1,
  parameter int   CNT_W   = 22,
  parameter int   MODE    = MODE_SYM,
  parameter logic RST_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);
  logic [N-1:0] s;
`ifdef GLITCH_FREE_MULTI_SYNC_EN
  logic [SYNC_STAGES-1:0][N-1:0] sq;
  always_ff @(posedge clk) begin
    sq <= rst ? {SYNC_STAGES{{N{RST_VAL}}}} : {sq[SYNC_STAGES-2:0], in};
  end
  assign s = sq[SYNC_STAGES-1];
`else
  assign s = in;
`endif
  for (genvar i = 0; i < N; i++) begin : g_chan
    glitch_free_chan #(.CNT_W(CNT_W), .MODE(MODE), .RST_VAL(RST_VAL)) u_chan (
      .clk (clk),
      .rst (rst),
      .s   (s[i]),
      .out (out[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
endmodule

// File: tb/tb_glitch_free_multi.sv
// tb_glitch_free_multi: directed scoreboard bench for symmetric and legacy debouncer instances
module tb_glitch_free_multi;
`ifdef GLITCH_FREE_MULTI_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  localparam int LAT = 8 + D;
  localparam int LEG = 1 + D;

  typedef struct packed {
    logic [1:0] o;
    logic [1:0] r;
    logic [1:0] f;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] in_v = 2'b00;
  logic [1:0] s_out, s_rise, s_fall, l_out, l_rise, l_fall;
  exp_t q_s[$], q_l[$];
  int checks = 0;
  int failures = 0;

  logic [1:0] m_out[2], m_rise[2], m_fall[2];
  int m_run[2][2];
  logic [1:0] m_sp1, m_sp2;

  always #5 clk = ~clk;

  glitch_free_multi #(.N(2), .CNT_W(3), .MODE(0), .RST_VAL(1'b0)) dut_s (
    .clk(clk), .rst(rst), .in(in_v), .out(s_out), .rise(s_rise), .fall(s_fall)
  );
  glitch_free_multi #(.N(2), .CNT_W(3), .MODE(1), .RST_VAL(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in(in_v), .out(l_out), .rise(l_rise), .fall(l_fall)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: a level is accepted once 2**CNT_W consecutive samples disagree with it.
  task automatic model(input logic r, input logic [1:0] v);
    logic [1:0] smp;
    smp = (D != 0) ? m_sp2 : v;
    if (r) begin
      m_sp1 = 2'b00;
      m_sp2 = 2'b00;
    end else begin
      m_sp2 = m_sp1;
      m_sp1 = v;
    end
    for (int m = 0; m < 2; m++) begin
      m_rise[m] = 2'b00;
      m_fall[m] = 2'b00;
      for (int c = 0; c < 2; c++) begin
        if (r) begin
          m_out[m][c] = 1'b0;
          m_run[m][c] = 0;
        end else if (smp[c] == m_out[m][c]) begin
          m_run[m][c] = 0;
        end else if (m == 1 && !smp[c]) begin
          m_out[m][c] = 1'b0;
          m_fall[m][c] = 1'b1;
          m_run[m][c] = 0;
        end else begin
          m_run[m][c]++;
          if (m_run[m][c] == 8) begin
            m_out[m][c] = smp[c];
            m_rise[m][c] = smp[c];
            m_fall[m][c] = !smp[c];
            m_run[m][c] = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [1:0] v);
    exp_t e;
    @(negedge clk);
    rst = r;
    in_v = v;
    model(r, v);
    q_s.push_back('{o: m_out[0], r: m_rise[0], f: m_fall[0]});
    q_l.push_back('{o: m_out[1], r: m_rise[1], f: m_fall[1]});
    @(posedge clk);
    #1;
    e = q_s.pop_front();
    chk("sym_out", s_out, e.o);
    chk("sym_rise", s_rise, e.r);
    chk("sym_fall", s_fall, e.f);
    e = q_l.pop_front();
    chk("leg_out", l_out, e.o);
    chk("leg_rise", l_rise, e.r);
    chk("leg_fall", l_fall, e.f);
  endtask

  initial begin
    m_sp1 = 2'b00;
    m_sp2 = 2'b00;
    for (int m = 0; m < 2; m++) begin
      m_out[m] = 2'b00;
      m_rise[m] = 2'b00;
      m_fall[m] = 2'b00;
      m_run[m][0] = 0;
      m_run[m][1] = 0;
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 2'b11);
      chk("reset_out", s_out, 2'b00);
      chk("reset_pulse", s_rise | s_fall, 2'b00);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 2'b00);
    for (int k = 1; k <= LAT; k++) begin
      step(1'b0, 2'b01);
      if (k == LAT - 1) chk("rise_early", s_out, 2'b00);
      if (k == LAT) begin
        chk("rise_out", s_out, 2'b01);
        chk("rise_pulse", s_rise, 2'b01);
      end
    end
    step(1'b0, 2'b01);
    chk("rise_drop", s_rise, 2'b00);
    chk("rise_ch1", s_out, 2'b01);
    for (int k = 1; k <= LAT; k++) begin
      step(1'b0, 2'b00);
      if (k == LEG) begin
        chk("leg_fall_out", l_out, 2'b00);
        chk("leg_fall_pulse", l_fall, 2'b01);
      end
      if (k == LAT - 1) chk("fall_early", s_out, 2'b01);
      if (k == LAT) begin
        chk("fall_out", s_out, 2'b00);
        chk("fall_pulse", s_fall, 2'b01);
      end
    end
    for (int k = 0; k < 3; k++) step(1'b0, 2'b00);
    for (int k = 0; k < 7; k++) step(1'b0, 2'b01);
    step(1'b0, 2'b00);
    for (int k = 1; k <= LAT; k++) begin
      step(1'b0, 2'b01);
      if (k == LAT - 1) chk("glitch_hold", s_out, 2'b00);
      if (k == LAT) chk("glitch_rise", s_rise, 2'b01);
    end
    for (int k = 0; k < LAT + 2; k++) step(1'b0, 2'b00);
    for (int k = 1; k <= LAT; k++) step(1'b0, 2'b11);
    chk("simul_rise", s_rise, 2'b11);
    chk("simul_out", s_out, 2'b11);
    for (int k = 0; k < LAT + 2; k++) step(1'b0, 2'b00);
    for (int k = 0; k < 4; k++) step(1'b0, 2'b11);
    step(1'b1, 2'b11);
    chk("midrst_out", s_out, 2'b00);
    chk("midrst_pulse", s_rise, 2'b00);
    for (int k = 1; k <= LAT; k++) begin
      step(1'b0, 2'b11);
      if (k == LAT - 1) chk("midrst_hold", s_out | s_rise, 2'b00);
      if (k == LAT) chk("midrst_rise", s_rise, 2'b11);
    end
    step(1'b0, 2'b10);
    step(1'b0, 2'b10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
